// File: rtl/branch_pred_ctrl.sv
// branch_pred_ctrl: 2-bit BHT + BTB next-PC prediction, EX-stage resolution, BTB update and branch statistics
module branch_pred_ctrl #(
  parameter int BHT_IDX_W = 6,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_f,
  input  logic        btb_hit,
  input  logic [31:0] btb_target,
  input  logic        stall,
  input  logic        bubble_e,
  input  logic        br_valid_e,
  input  logic        br_taken_e,
  input  logic [31:0] br_target_e,
  input  logic [31:0] pc_e,
  output logic [31:0] pred_npc_f,
  output logic        pred_taken_f,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush_fd,
  output logic        btb_we,
  output logic [31:0] btb_wpc,
  output logic [31:0] btb_wtarget,
  output logic [31:0] br_cnt,
  output logic [31:0] miss_cnt
);
  logic [1:0] bht [2**BHT_IDX_W];
  logic [BHT_IDX_W-1:0] idxF, idxE;
  logic takenD, hitD, takenE, hitE, mispredict;
  logic [31:0] targetD, targetE;
  logic [1:0] cntE;
  always_comb begin
    idxF = pc_f[BHT_IDX_W+1:2];
    idxE = pc_e[BHT_IDX_W+1:2];
    cntE = bht[idxE];
    pred_taken_f = !rst & btb_hit & bht[idxF][1];
    mispredict = br_valid_e & ((takenE != br_taken_e) | (br_taken_e & takenE & (targetE != br_target_e)));
    redirect = !rst & mispredict;
    flush_fd = redirect;
    redirect_pc = br_taken_e ? br_target_e : pc_e + 32'd4;
    pred_npc_f = redirect ? redirect_pc : (pred_taken_f ? btb_target : pc_f + 32'd4);
    btb_we = !rst & br_valid_e & br_taken_e & (!hitE | (targetE != br_target_e));
    btb_wpc = pc_e;
    btb_wtarget = br_target_e;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**BHT_IDX_W; i++) bht[i] <= CNT_INIT;
      {takenD, hitD, targetD, takenE, hitE, targetE} <= '0;
      br_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      if (br_valid_e) begin
        bht[idxE] <= br_taken_e ? (cntE == 2'd3 ? cntE : cntE + 2'd1) : (cntE == 2'd0 ? cntE : cntE - 2'd1);
        br_cnt <= br_cnt + 32'd1;
      end
      if (mispredict) miss_cnt <= miss_cnt + 32'd1;
      // redirect squashes both stages; stall freezes them; a bubble empties only E
      if (mispredict) begin
        {takenD, hitD, targetD, takenE, hitE, targetE} <= '0;
      end else if (!stall) begin
        {takenE, hitE, targetE} <= bubble_e ? 34'd0 : {takenD, hitD, targetD};
        {takenD, hitD, targetD} <= {pred_taken_f, btb_hit, btb_target};
      end
    end
  end
endmodule
